// File: rtl/psum_collector_pkg.sv
// Shared definitions for the partial-sum collector.
//   depthDefault : log2 of the mesh dimension (D = 1 << depth rows)
//   wDefault     : partial-sum lane width in bits
//   abDefault    : output-buffer address width
//   pwDefault    : pass/tile counter width
//   stateT       : collector state encoding
package psum_collector_pkg;

  localparam int depthDefault = 2;
  localparam int wDefault     = 8;
  localparam int abDefault    = 11;
  localparam int pwDefault    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2,
    FIN   = 2'd3
  } stateT;

endpackage

// File: rtl/psum_collector_if.sv
// Job, partial-sum and output-buffer signals of the collector.
//   master : job launcher / mesh / output buffer side (drives start, config,
//            psumIn/psumValid, outReady)
//   slave  : the collector (drives psumReady, outData/outAddr/outValid,
//            busy, done)
interface psum_collector_if
  import psum_collector_pkg::*;
#(
  parameter int depth = depthDefault,
  parameter int W     = wDefault,
  parameter int Ab    = abDefault,
  parameter int Pw    = pwDefault
);

  localparam int D = 1 << depth;

  logic          start;
  logic [Pw-1:0] numPasses;
  logic [Pw-1:0] numTiles;
  logic [Ab-1:0] baseAddr;

  logic [W*D-1:0] psumIn;
  logic           psumValid;
  logic           psumReady;

  logic [W*D-1:0] outData;
  logic [Ab-1:0]  outAddr;
  logic           outValid;
  logic           outReady;

  logic busy;
  logic done;

  modport master (
    output start, numPasses, numTiles, baseAddr, psumIn, psumValid, outReady,
    input  psumReady, outData, outAddr, outValid, busy, done
  );

  modport slave (
    input  start, numPasses, numTiles, baseAddr, psumIn, psumValid, outReady,
    output psumReady, outData, outAddr, outValid, busy, done
  );

endinterface

// File: rtl/psum_lane_acc.sv
// One W-bit accumulator lane.
//   CLK, RSTn : clock, async active-low reset
//   en        : accept din this cycle
//   first     : load din instead of adding (first pass of a tile)
//   din       : incoming partial sum
//   acc       : registered accumulation (wraps modulo 2^W)
module psum_lane_acc #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         en,
  input  logic         first,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      acc <= '0;
    end else if (en) begin
      acc <= first ? din : acc + din;
    end
  end

endmodule

// File: rtl/psum_collector.sv
// Collects mesh partial sums over numPasses passes per tile and emits one
// accumulated row vector per tile to the output buffer, for numTiles tiles
// at consecutive addresses starting at baseAddr.
//   CLK, RSTn : clock, async active-low reset
//   bus       : psum_collector_if.slave (job config, psum stream, output
//               write port, busy/done status)
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting psum beats for the current tile
// OUT   | presenting the finished tile until outReady
// FIN   | one-cycle done pulse, then back to IDLE
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int depth = depthDefault,
  parameter int W     = wDefault,
  parameter int Ab    = abDefault,
  parameter int Pw    = pwDefault
) (
  input logic              CLK,
  input logic              RSTn,
  psum_collector_if.slave  bus
);

  localparam int D = 1 << depth;

  stateT          state;
  logic [Pw-1:0]  passCnt;
  logic [Pw-1:0]  tileCnt;
  logic [Pw-1:0]  numPassesQ;
  logic [Pw-1:0]  numTilesQ;
  logic [Ab-1:0]  outAddrQ;
  logic           outValidQ;
  logic           psumReadyQ;
  logic           busyQ;
  logic           doneQ;
  logic [W*D-1:0] accLanes;

  logic beat;
  logic firstPass;

  // psumReadyQ is high exactly while in ACCUM, so it also gates the lanes.
  assign beat      = bus.psumValid && psumReadyQ;
  assign firstPass = (passCnt == '0);

  for (genvar i = 0; i < D; i++) begin : gLane
    psum_lane_acc #(.W(W)) uLane (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .en    (beat),
      .first (firstPass),
      .din   (bus.psumIn[W*(i+1)-1 -: W]),
      .acc   (accLanes[W*(i+1)-1 -: W])
    );
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      passCnt    <= '0;
      tileCnt    <= '0;
      numPassesQ <= '0;
      numTilesQ  <= '0;
      outAddrQ   <= '0;
      outValidQ  <= 1'b0;
      psumReadyQ <= 1'b0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busyQ <= 1'b1;
            if (bus.numPasses != '0 && bus.numTiles != '0) begin
              numPassesQ <= bus.numPasses;
              numTilesQ  <= bus.numTiles;
              passCnt    <= '0;
              tileCnt    <= '0;
              outAddrQ   <= bus.baseAddr;
              psumReadyQ <= 1'b1;
              state      <= ACCUM;
            end else begin
              doneQ <= 1'b1;
              state <= FIN;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            if (passCnt == numPassesQ - Pw'(1)) begin
              psumReadyQ <= 1'b0;
              outValidQ  <= 1'b1;
              state      <= OUT;
            end else begin
              passCnt <= passCnt + Pw'(1);
            end
          end
        end
        OUT: begin
          if (bus.outReady) begin
            outValidQ <= 1'b0;
            if (tileCnt == numTilesQ - Pw'(1)) begin
              doneQ <= 1'b1;
              state <= FIN;
            end else begin
              tileCnt    <= tileCnt + Pw'(1);
              outAddrQ   <= outAddrQ + Ab'(1);
              passCnt    <= '0;
              psumReadyQ <= 1'b1;
              state      <= ACCUM;
            end
          end
        end
        FIN: begin
          doneQ <= 1'b0;
          busyQ <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.psumReady = psumReadyQ;
  assign bus.outData   = accLanes;
  assign bus.outAddr   = outAddrQ;
  assign bus.outValid  = outValidQ;
  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;

endmodule

// File: tb/tb_psum_collector.sv
module tb_psum_collector;

  localparam int depth = 2;
  localparam int W     = 8;
  localparam int Ab    = 11;
  localparam int Pw    = 8;
  localparam int LW    = W * (1 << depth);

  logic CLK = 1'b0;
  logic RSTn;
  int   vecs = 0;
  int   errs = 0;

  always #5 CLK = ~CLK;

  psum_collector_if #(.depth(depth), .W(W), .Ab(Ab), .Pw(Pw)) bus ();

  psum_collector #(.depth(depth), .W(W), .Ab(Ab), .Pw(Pw)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  task automatic startJob(input logic [Pw-1:0] np, input logic [Pw-1:0] nt,
                          input logic [Ab-1:0] ba);
    bus.start = 1'b1; bus.numPasses = np; bus.numTiles = nt; bus.baseAddr = ba;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic driveBeat(input logic [LW-1:0] d);
    bus.psumValid = 1'b1; bus.psumIn = d;
    @(negedge CLK);
    bus.psumValid = 1'b0; bus.psumIn = '0;
  endtask

  task automatic test_reset;
    RSTn = 1'b0;
    bus.start = 0; bus.numPasses = 0; bus.numTiles = 0; bus.baseAddr = 0;
    bus.psumIn = 0; bus.psumValid = 0; bus.outReady = 0;
    #12;
    vecs++; if ({bus.psumReady, bus.outValid, bus.busy, bus.done} !== 4'b0) begin
      errs++; $display("FAIL reset_flags: got %b want 0000", {bus.psumReady, bus.outValid, bus.busy, bus.done}); end
    vecs++; if (bus.outData !== '0 || bus.outAddr !== '0) begin
      errs++; $display("FAIL reset_data: got %h/%h want 0/0", bus.outData, bus.outAddr); end
    @(negedge CLK); RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    vecs++; if ({bus.psumReady, bus.outValid, bus.busy, bus.done} !== 4'b0 || bus.outAddr !== '0) begin
      errs++; $display("FAIL reset_idle: got %b/%h want 0000/0", {bus.psumReady, bus.outValid, bus.busy, bus.done}, bus.outAddr); end
  endtask

  task automatic test_single;
    startJob(8'd1, 8'd1, 11'd5);
    vecs++; if (bus.psumReady !== 1'b1 || bus.busy !== 1'b1 || bus.outAddr !== 11'd5) begin
      errs++; $display("FAIL single_accum: got rdy=%b busy=%b addr=%0d want 1 1 5", bus.psumReady, bus.busy, bus.outAddr); end
    driveBeat({8'd4, 8'd3, 8'd2, 8'd1});
    vecs++; if (bus.outValid !== 1'b1 || bus.psumReady !== 1'b0) begin
      errs++; $display("FAIL single_outValid: got v=%b rdy=%b want 1 0", bus.outValid, bus.psumReady); end
    vecs++; if (bus.outData !== 32'h04030201 || bus.outAddr !== 11'd5) begin
      errs++; $display("FAIL single_outData: got %h@%0d want 04030201@5", bus.outData, bus.outAddr); end
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    vecs++; if (bus.done !== 1'b1 || bus.outValid !== 1'b0 || bus.busy !== 1'b1) begin
      errs++; $display("FAIL single_done: got done=%b v=%b busy=%b want 1 0 1", bus.done, bus.outValid, bus.busy); end
    @(negedge CLK);
    vecs++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL single_idle: got done=%b busy=%b want 0 0", bus.done, bus.busy); end
  endtask

  task automatic test_three_pass;
    startJob(8'd3, 8'd1, 11'd0);
    driveBeat({4{8'd100}});
    driveBeat({4{8'd100}});
    vecs++; if (bus.outValid !== 1'b0 || bus.psumReady !== 1'b1) begin
      errs++; $display("FAIL three_early: got v=%b rdy=%b want 0 1", bus.outValid, bus.psumReady); end
    driveBeat({4{8'd100}});
    vecs++; if (bus.outValid !== 1'b1 || bus.outData !== {4{8'd44}}) begin
      errs++; $display("FAIL three_sum: got v=%b %h want 1 2c2c2c2c", bus.outValid, bus.outData); end
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    vecs++; if (bus.done !== 1'b1) begin
      errs++; $display("FAIL three_done: got %b want 1", bus.done); end
    @(negedge CLK);
  endtask

  task automatic test_two_tiles;
    startJob(8'd2, 8'd2, 11'd2047);
    driveBeat({8'd10, 8'd20, 8'd30, 8'd40});
    driveBeat({8'd1, 8'd1, 8'd1, 8'd1});
    vecs++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h0b151f29 || bus.outAddr !== 11'd2047) begin
      errs++; $display("FAIL tiles_t0: got v=%b %h@%0d want 1 0b151f29@2047", bus.outValid, bus.outData, bus.outAddr); end
    for (int c = 0; c < 5; c++) begin
      bus.psumValid = 1'b1; bus.psumIn = {4{8'hff}};
      @(negedge CLK);
      vecs++; if (bus.outValid !== 1'b1 || bus.psumReady !== 1'b0 || bus.outData !== 32'h0b151f29 || bus.outAddr !== 11'd2047) begin
        errs++; $display("FAIL tiles_hold%0d: got v=%b rdy=%b %h@%0d want 1 0 0b151f29@2047", c, bus.outValid, bus.psumReady, bus.outData, bus.outAddr); end
    end
    bus.psumValid = 1'b0; bus.psumIn = '0;
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    vecs++; if (bus.outAddr !== 11'd0 || bus.psumReady !== 1'b1 || bus.outValid !== 1'b0 || bus.done !== 1'b0) begin
      errs++; $display("FAIL tiles_wrap: got addr=%0d rdy=%b v=%b done=%b want 0 1 0 0", bus.outAddr, bus.psumReady, bus.outValid, bus.done); end
    driveBeat({4{8'd5}});
    driveBeat({4{8'd250}});
    vecs++; if (bus.outValid !== 1'b1 || bus.outData !== {4{8'd255}} || bus.outAddr !== 11'd0) begin
      errs++; $display("FAIL tiles_t1: got v=%b %h@%0d want 1 ffffffff@0", bus.outValid, bus.outData, bus.outAddr); end
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    vecs++; if (bus.done !== 1'b1) begin
      errs++; $display("FAIL tiles_done: got %b want 1", bus.done); end
    @(negedge CLK);
  endtask

  task automatic test_zero_tiles;
    startJob(8'd3, 8'd0, 11'd9);
    vecs++; if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.outValid !== 1'b0 || bus.psumReady !== 1'b0) begin
      errs++; $display("FAIL zero_fin: got done=%b busy=%b v=%b rdy=%b want 1 1 0 0", bus.done, bus.busy, bus.outValid, bus.psumReady); end
    @(negedge CLK);
    vecs++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.outValid !== 1'b0) begin
      errs++; $display("FAIL zero_idle: got done=%b busy=%b v=%b want 0 0 0", bus.done, bus.busy, bus.outValid); end
    startJob(8'd0, 8'd4, 11'd9);
    vecs++; if (bus.done !== 1'b1 || bus.outValid !== 1'b0) begin
      errs++; $display("FAIL zero_passes: got done=%b v=%b want 1 0", bus.done, bus.outValid); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    startJob(8'd3, 8'd1, 11'd7);
    driveBeat({4{8'd9}});
    #2 RSTn = 1'b0;
    #1;
    vecs++; if ({bus.psumReady, bus.outValid, bus.busy, bus.done} !== 4'b0 || bus.outData !== '0 || bus.outAddr !== '0) begin
      errs++; $display("FAIL rstmid_clear: got %b %h@%0d want 0000 0@0", {bus.psumReady, bus.outValid, bus.busy, bus.done}, bus.outData, bus.outAddr); end
    @(negedge CLK); RSTn = 1'b1;
    @(negedge CLK);
    vecs++; if (bus.busy !== 1'b0 || bus.outData !== '0 || bus.psumReady !== 1'b0) begin
      errs++; $display("FAIL rstmid_quiet: got busy=%b %h rdy=%b want 0 0 0", bus.busy, bus.outData, bus.psumReady); end
    startJob(8'd2, 8'd1, 11'd3);
    driveBeat({8'd1, 8'd2, 8'd3, 8'd4});
    driveBeat({4{8'd1}});
    vecs++; if (bus.outValid !== 1'b1 || bus.outData !== 32'h02030405 || bus.outAddr !== 11'd3) begin
      errs++; $display("FAIL rstmid_fresh: got v=%b %h@%0d want 1 02030405@3", bus.outValid, bus.outData, bus.outAddr); end
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_ignored;
    startJob(8'd1, 8'd2, 11'd10);
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    vecs++; if (bus.psumReady !== 1'b1 || bus.outValid !== 1'b0 || bus.outAddr !== 11'd10) begin
      errs++; $display("FAIL ign_outReady: got rdy=%b v=%b addr=%0d want 1 0 10", bus.psumReady, bus.outValid, bus.outAddr); end
    driveBeat({4{8'd7}});
    for (int c = 0; c < 3; c++) begin
      bus.psumValid = 1'b1; bus.psumIn = {4{8'd1}};
      bus.start = 1'b1; bus.numPasses = 8'd4; bus.numTiles = 8'd1; bus.baseAddr = 11'd100;
      @(negedge CLK);
      vecs++; if (bus.outValid !== 1'b1 || bus.outData !== {4{8'd7}} || bus.outAddr !== 11'd10) begin
        errs++; $display("FAIL ign_out%0d: got v=%b %h@%0d want 1 07070707@10", c, bus.outValid, bus.outData, bus.outAddr); end
    end
    bus.psumValid = 1'b0; bus.start = 1'b0;
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    vecs++; if (bus.outAddr !== 11'd11 || bus.psumReady !== 1'b1) begin
      errs++; $display("FAIL ign_tile1: got addr=%0d rdy=%b want 11 1", bus.outAddr, bus.psumReady); end
    driveBeat({4{8'd3}});
    vecs++; if (bus.outValid !== 1'b1 || bus.outData !== {4{8'd3}}) begin
      errs++; $display("FAIL ign_sum: got v=%b %h want 1 03030303", bus.outValid, bus.outData); end
    bus.outReady = 1'b1; @(negedge CLK); bus.outReady = 1'b0;
    vecs++; if (bus.done !== 1'b1) begin
      errs++; $display("FAIL ign_done: got %b want 1", bus.done); end
    @(negedge CLK);
    vecs++; if (bus.busy !== 1'b0) begin
      errs++; $display("FAIL ign_idle: got busy=%b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_pass();
    test_two_tiles();
    test_zero_tiles();
    test_reset_mid();
    test_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
